// File: rtl/decode_stage_if.sv
// Handshake and control-bundle bundle between fetch, decode_stage and execute.
// master = fetch/execute side that drives the instruction and consumes the bundle,
// slave  = the decoder itself.
interface decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             trap_clr;
  logic             rf_we;
  logic             mem_we;
  logic             mem_re;
  logic             has_imm;
  logic             branch;
  logic             branch_ne;
  logic             jump;
  logic [3:0]       alu_op;
  logic [XLEN-1:0]  imm;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             illegal;
  logic             trapped;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, instr, out_ready, flush, trap_clr,
    input  in_ready, out_valid, rf_we, mem_we, mem_re, has_imm, branch, branch_ne,
           jump, alu_op, imm, rd, rs1, rs2, illegal, trapped, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, out_ready, flush, trap_clr,
    output in_ready, out_valid, rf_we, mem_we, mem_re, has_imm, branch, branch_ne,
           jump, alu_op, imm, rd, rs1, rs2, illegal, trapped, illegal_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Registered, valid/ready handshaked RV32I-subset decoder with flush,
// illegal-instruction trap state and a saturating illegal counter.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

  typedef struct packed {
    logic            rf_we;
    logic            mem_we;
    logic            mem_re;
    logic            has_imm;
    logic            branch;
    logic            branch_ne;
    logic            jump;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            illegal;
  } bundle_t;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_PASS = 4'b1000;

  state_e           state_q;
  logic             out_valid_q;
  bundle_t          bundle_q;
  bundle_t          bundle_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f3_logic_ok;
  logic [3:0] f3_alu;

  // Widen a 32-bit signed immediate to XLEN, replicating the sign bit.
  function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  // ADD/XOR/OR/AND family: f3 = 000/100/110/111; op code is f3 itself except for add.
  assign f3_logic_ok = (f3 == 3'b000) || (f3[2] && (f3 != 3'b101));
  assign f3_alu      = (f3 == 3'b000) ? ALU_ADD : {1'b0, f3};

  assign bus.in_ready = (state_q == RUN) && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Combinational decode of the incoming instruction into a candidate bundle.
  always_comb begin
    bundle_d         = '0;
    bundle_d.rd      = bus.instr[11:7];
    bundle_d.rs1     = bus.instr[19:15];
    bundle_d.rs2     = bus.instr[24:20];
    bundle_d.illegal = 1'b1;
    case (opcode)
      7'b0010011: if (f3_logic_ok) begin
        bundle_d.illegal = 1'b0;
        bundle_d.rf_we   = 1'b1;
        bundle_d.has_imm = 1'b1;
        bundle_d.alu_op  = f3_alu;
        bundle_d.imm     = sext({{20{bus.instr[31]}}, bus.instr[31:20]});
      end
      7'b0110011: begin
        if (f7 == 7'b0000000 && f3_logic_ok) begin
          bundle_d.illegal = 1'b0;
          bundle_d.rf_we   = 1'b1;
          bundle_d.alu_op  = f3_alu;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          bundle_d.illegal = 1'b0;
          bundle_d.rf_we   = 1'b1;
          bundle_d.alu_op  = ALU_SUB;
        end
      end
      7'b0000011: if (f3 == 3'b010) begin
        bundle_d.illegal = 1'b0;
        bundle_d.rf_we   = 1'b1;
        bundle_d.mem_re  = 1'b1;
        bundle_d.has_imm = 1'b1;
        bundle_d.alu_op  = ALU_ADD;
        bundle_d.imm     = sext({{20{bus.instr[31]}}, bus.instr[31:20]});
      end
      7'b0100011: if (f3 == 3'b010) begin
        bundle_d.illegal = 1'b0;
        bundle_d.mem_we  = 1'b1;
        bundle_d.has_imm = 1'b1;
        bundle_d.alu_op  = ALU_ADD;
        bundle_d.imm     = sext({{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]});
      end
      7'b1100011: if (f3[2:1] == 2'b00) begin
        bundle_d.illegal   = 1'b0;
        bundle_d.branch    = 1'b1;
        bundle_d.branch_ne = f3[0];
        bundle_d.alu_op    = ALU_SUB;
        bundle_d.imm       = sext({{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                                   bus.instr[11:8], 1'b0});
      end
      7'b0110111: begin
        bundle_d.illegal = 1'b0;
        bundle_d.rf_we   = 1'b1;
        bundle_d.has_imm = 1'b1;
        bundle_d.alu_op  = ALU_PASS;
        bundle_d.imm     = sext({bus.instr[31:12], 12'b0});
      end
      7'b1101111: begin
        bundle_d.illegal = 1'b0;
        bundle_d.rf_we   = 1'b1;
        bundle_d.jump    = 1'b1;
        bundle_d.alu_op  = ALU_NONE;
        bundle_d.imm     = sext({{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                                 bus.instr[30:21], 1'b0});
      end
      default: ;
    endcase
    if (bundle_d.illegal) begin
      bundle_d.imm = '0;
    end
  end

  // Output register, handshake and RUN/TRAP state with the illegal counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      cnt_q       <= '0;
    end else begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        bundle_q    <= bundle_d;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        RUN: if (accept && bundle_d.illegal) begin
          state_q <= TRAP;
          cnt_q   <= sat_inc(cnt_q);
        end
        TRAP: if (bus.trap_clr) begin
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.rf_we       = bundle_q.rf_we;
  assign bus.mem_we      = bundle_q.mem_we;
  assign bus.mem_re      = bundle_q.mem_re;
  assign bus.has_imm     = bundle_q.has_imm;
  assign bus.branch      = bundle_q.branch;
  assign bus.branch_ne   = bundle_q.branch_ne;
  assign bus.jump        = bundle_q.jump;
  assign bus.alu_op      = bundle_q.alu_op;
  assign bus.imm         = bundle_q.imm;
  assign bus.rd          = bundle_q.rd;
  assign bus.rs1         = bundle_q.rs1;
  assign bus.rs2         = bundle_q.rs2;
  assign bus.illegal     = bundle_q.illegal;
  assign bus.trapped     = (state_q == TRAP);
  assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance plus a CNT_W=2 instance
// for counter saturation.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SW   = 32'hFE20AE23;
  localparam logic [31:0] I_BNE  = 32'hFE209CE3;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_BAD  = 32'h00000000;

  decode_stage_if #(.XLEN(32), .CNT_W(8)) a ();
  decode_stage_if #(.XLEN(32), .CNT_W(2)) b ();

  decode_stage #(.XLEN(32), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  decode_stage #(.XLEN(32), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", a.out_valid); end
    n_cmp++; if ({a.rf_we, a.mem_we, a.mem_re, a.has_imm, a.branch, a.jump, a.illegal, a.alu_op} !== 11'd0)
      begin n_fail++; $display("FAIL rst_ctrl: got nonzero control bundle"); end
    n_cmp++; if (a.imm !== 32'd0) begin n_fail++; $display("FAIL rst_imm: got %h want 0", a.imm); end
    n_cmp++; if (a.trapped !== 1'b0 || a.illegal_cnt !== 8'd0)
      begin n_fail++; $display("FAIL rst_state: trapped %0b cnt %0d want 0/0", a.trapped, a.illegal_cnt); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", a.in_ready); end
  endtask

  task automatic test_addi();
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1;
    a.instr     = I_ADDI;
    step();
    a.in_valid = 1'b0;
    n_cmp++; if (a.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b want 1", a.out_valid); end
    n_cmp++; if ({a.rf_we, a.has_imm, a.mem_we, a.illegal, a.alu_op} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'b0001})
      begin n_fail++; $display("FAIL addi_ctrl: rf_we %0b has_imm %0b alu %b illegal %0b", a.rf_we, a.has_imm, a.alu_op, a.illegal); end
    n_cmp++; if (a.imm !== 32'h00000005 || a.rd !== 5'd1)
      begin n_fail++; $display("FAIL addi_fields: imm %h rd %0d want 00000005/1", a.imm, a.rd); end
    step();
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0b want 0", a.out_valid); end
  endtask

  task automatic test_sw_bne();
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1;
    a.instr     = I_SW;
    step();
    a.instr = I_BNE;
    n_cmp++; if ({a.out_valid, a.mem_we, a.rf_we, a.has_imm} !== 4'b1101)
      begin n_fail++; $display("FAIL sw_ctrl: valid %0b mem_we %0b rf_we %0b has_imm %0b", a.out_valid, a.mem_we, a.rf_we, a.has_imm); end
    n_cmp++; if (a.imm !== 32'hFFFFFFFC || a.rs1 !== 5'd1 || a.rs2 !== 5'd2)
      begin n_fail++; $display("FAIL sw_fields: imm %h rs1 %0d rs2 %0d want FFFFFFFC/1/2", a.imm, a.rs1, a.rs2); end
    step();
    a.in_valid = 1'b0;
    n_cmp++; if ({a.out_valid, a.branch, a.branch_ne, a.has_imm, a.rf_we, a.alu_op} !== {5'b11100, 4'b0010})
      begin n_fail++; $display("FAIL bne_ctrl: branch %0b ne %0b has_imm %0b alu %b", a.branch, a.branch_ne, a.has_imm, a.alu_op); end
    n_cmp++; if (a.imm !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL bne_imm: got %h want FFFFFFF8", a.imm); end
    step();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [10:0] ctrl;
    logic [31:0] imm;
    logic [4:0]  rd;
  } vec_t;

  task automatic test_other_ops();
    vec_t v[3];
    logic [10:0] got;
    v[0] = '{32'h0040A183, {7'b1011000, 4'b0001}, 32'h00000004, 5'd3};
    v[1] = '{32'h123452B7, {7'b1001000, 4'b1000}, 32'h12345000, 5'd5};
    v[2] = '{32'hFFDFF0EF, {7'b1000010, 4'b0000}, 32'hFFFFFFFC, 5'd1};
    a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a.in_valid = 1'b1;
      a.instr    = v[i].instr;
      step();
      got = {a.rf_we, a.mem_we, a.mem_re, a.has_imm, a.branch, a.jump, a.illegal, a.alu_op};
      n_cmp++; if (got !== v[i].ctrl || a.out_valid !== 1'b1)
        begin n_fail++; $display("FAIL op%0d_ctrl: got %b valid %0b want %b", i, got, a.out_valid, v[i].ctrl); end
      n_cmp++; if (a.imm !== v[i].imm || a.rd !== v[i].rd)
        begin n_fail++; $display("FAIL op%0d_fields: imm %h rd %0d want %h/%0d", i, a.imm, a.rd, v[i].imm, v[i].rd); end
    end
    a.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    a.out_ready = 1'b0;
    a.in_valid  = 1'b1;
    a.instr     = I_ADDI;
    step();
    a.instr = I_SUB;
    #1;
    n_cmp++; if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_hold: got %0b want 0", a.in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (a.out_valid !== 1'b1 || a.alu_op !== 4'b0001 || a.imm !== 32'd5 || a.has_imm !== 1'b1)
        begin n_fail++; $display("FAIL b2b_hold%0d: valid %0b alu %b imm %h", k, a.out_valid, a.alu_op, a.imm); end
    end
    a.out_ready = 1'b1;
    #1;
    n_cmp++; if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_go: got %0b want 1", a.in_ready); end
    step();
    a.in_valid = 1'b0;
    n_cmp++; if ({a.out_valid, a.rf_we, a.has_imm, a.alu_op} !== {3'b110, 4'b0010})
      begin n_fail++; $display("FAIL b2b_sub_ctrl: valid %0b rf_we %0b has_imm %0b alu %b", a.out_valid, a.rf_we, a.has_imm, a.alu_op); end
    n_cmp++; if (a.rd !== 5'd0 || a.rs1 !== 5'd1 || a.rs2 !== 5'd2)
      begin n_fail++; $display("FAIL b2b_sub_regs: rd %0d rs1 %0d rs2 %0d want 0/1/2", a.rd, a.rs1, a.rs2); end
    step();
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b want 0", a.out_valid); end
  endtask

  task automatic test_illegal();
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1;
    a.instr     = I_BAD;
    step();
    a.instr = I_ADDI;
    n_cmp++; if ({a.out_valid, a.illegal, a.trapped, a.rf_we, a.alu_op} !== {4'b1110, 4'b0000})
      begin n_fail++; $display("FAIL ill_bundle: valid %0b illegal %0b trapped %0b rf_we %0b alu %b", a.out_valid, a.illegal, a.trapped, a.rf_we, a.alu_op); end
    n_cmp++; if (a.illegal_cnt !== 8'd1) begin n_fail++; $display("FAIL ill_cnt: got %0d want 1", a.illegal_cnt); end
    n_cmp++; if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL ill_in_ready: got %0b want 0", a.in_ready); end
    step();
    a.in_valid = 1'b0;
    n_cmp++; if (a.out_valid !== 1'b0 || a.trapped !== 1'b1 || a.illegal_cnt !== 8'd1)
      begin n_fail++; $display("FAIL ill_ignore: valid %0b trapped %0b cnt %0d want 0/1/1", a.out_valid, a.trapped, a.illegal_cnt); end
    a.trap_clr = 1'b1;
    step();
    a.trap_clr = 1'b0;
    #1;
    n_cmp++; if (a.trapped !== 1'b0 || a.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL ill_clear: trapped %0b in_ready %0b want 0/1", a.trapped, a.in_ready); end
  endtask

  task automatic test_flush();
    a.out_ready = 1'b0;
    a.in_valid  = 1'b1;
    a.instr     = I_ADDI;
    step();
    a.instr = I_SW;
    a.flush = 1'b1;
    #1;
    n_cmp++; if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0b want 0", a.in_ready); end
    step();
    a.flush    = 1'b0;
    a.in_valid = 1'b0;
    n_cmp++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", a.out_valid); end
    n_cmp++; if (a.mem_we !== 1'b0 || a.rf_we !== 1'b1)
      begin n_fail++; $display("FAIL flush_no_accept: mem_we %0b rf_we %0b want 0/1", a.mem_we, a.rf_we); end
    a.out_ready = 1'b1;
    step();
  endtask

  task automatic test_saturate();
    logic [1:0] want[4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3;
    b.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b.in_valid = 1'b1;
      b.instr    = I_BAD;
      step();
      b.in_valid = 1'b0;
      n_cmp++; if (b.illegal_cnt !== want[k] || b.trapped !== 1'b1)
        begin n_fail++; $display("FAIL sat%0d: cnt %0d trapped %0b want %0d/1", k, b.illegal_cnt, b.trapped, want[k]); end
      b.trap_clr = 1'b1;
      step();
      b.trap_clr = 1'b0;
    end
  endtask

  task automatic test_reset_mid_hold();
    a.out_ready = 1'b0;
    a.in_valid  = 1'b1;
    a.instr     = I_BAD;
    step();
    a.in_valid = 1'b0;
    step();
    n_cmp++; if (a.out_valid !== 1'b1 || a.trapped !== 1'b1 || a.illegal_cnt !== 8'd2)
      begin n_fail++; $display("FAIL mid_pre: valid %0b trapped %0b cnt %0d want 1/1/2", a.out_valid, a.trapped, a.illegal_cnt); end
    rst_n = 1'b0;
    step();
    n_cmp++; if ({a.out_valid, a.illegal, a.trapped, a.rf_we, a.alu_op, a.rd} !== 13'd0 || a.illegal_cnt !== 8'd0 || a.imm !== 32'd0)
      begin n_fail++; $display("FAIL mid_reset: valid %0b illegal %0b trapped %0b cnt %0d", a.out_valid, a.illegal, a.trapped, a.illegal_cnt); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %0b want 1", a.in_ready); end
  endtask

  initial begin
    a.in_valid = 1'b0; a.instr = 32'd0; a.out_ready = 1'b0; a.flush = 1'b0; a.trap_clr = 1'b0;
    b.in_valid = 1'b0; b.instr = 32'd0; b.out_ready = 1'b0; b.flush = 1'b0; b.trap_clr = 1'b0;
    test_reset();
    test_addi();
    test_sw_bne();
    test_other_ops();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_saturate();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
